// File: rtl/varredura_matriz_if.sv
// ============================================================================
// Module  : varredura_matriz_if
// Brief   : Bus bundle between the frame writer and the LED row-scan controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface varredura_matriz_if #(
    parameter int COLS = 5
);
    logic            enable_i;
    logic            wr_en_i;
    logic [2:0]      wr_row_i;
    logic [COLS-1:0] wr_data_i;
    logic            swap_req_i;
    logic            swap_ack_o;
    logic [2:0]      func_o;
    logic [COLS-1:0] col_data_o;
    logic            frame_start_o;

    modport master (
        output enable_i, wr_en_i, wr_row_i, wr_data_i, swap_req_i,
        input  swap_ack_o, func_o, col_data_o, frame_start_o
    );

    modport slave (
        input  enable_i, wr_en_i, wr_row_i, wr_data_i, swap_req_i,
        output swap_ack_o, func_o, col_data_o, frame_start_o
    );
endinterface

`default_nettype wire

// File: rtl/varredura_matriz.sv
// ============================================================================
// Module  : varredura_matriz
// Brief   : Row-scan controller with a double-buffered 7-row frame store.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module varredura_matriz #(
    parameter int COLS      = 5,
    parameter int DIV_WIDTH = 16,
    parameter int DIV_MAX   = 49999
) (
    input  wire                 clk,
    input  wire                 rst,
    varredura_matriz_if.slave   bus
);
    localparam logic [DIV_WIDTH-1:0] c_div_max = DIV_WIDTH'(DIV_MAX);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     row_q, row_d;
    logic [DIV_WIDTH-1:0]           presc_q, presc_d;
    logic                           pend_q, pend_d;
    logic                           sel_q, sel_d;
    logic [COLS-1:0]                col_q, col_d;
    logic                           ack_q;
    logic                           fs_q, fs_d;
    logic [1:0][7:0][COLS-1:0]      mem_q;

    logic                           wrap_d;
    logic                           swap_d;
    logic                           wr_hit_d;

    always_comb begin
        wrap_d   = (state_q == SCAN) && (presc_q == c_div_max) && (row_q == 3'd7);
        swap_d   = pend_q && ((state_q == IDLE) || (bus.enable_i && wrap_d));
        sel_d    = sel_q ^ swap_d;
        pend_d   = bus.swap_req_i | (pend_q & ~swap_d);
        wr_hit_d = bus.wr_en_i && (bus.wr_row_i != 3'd0);

        state_d  = IDLE;
        row_d    = 3'd0;
        presc_d  = '0;
        fs_d     = 1'b0;
        if (bus.enable_i) begin
            state_d = SCAN;
            if (state_q == IDLE) begin
                row_d = 3'd1;
                fs_d  = 1'b1;
            end else if (presc_q == c_div_max) begin
                row_d = (row_q == 3'd7) ? 3'd1 : row_q + 3'd1;
                fs_d  = (row_q == 3'd7);
            end else begin
                row_d   = row_q;
                presc_d = presc_q + DIV_WIDTH'(1);
            end
        end

        // A write on the swap edge lands in the bank becoming the display,
        // so forward it to keep col_data consistent with that bank.
        col_d = '0;
        if (bus.enable_i) begin
            col_d = mem_q[sel_d][row_d];
            if (wr_hit_d && swap_d && (bus.wr_row_i == row_d)) begin
                col_d = bus.wr_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            presc_q <= '0;
            pend_q  <= 1'b0;
            sel_q   <= 1'b0;
            col_q   <= '0;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            presc_q <= presc_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            col_q   <= col_d;
            ack_q   <= swap_d;
            fs_q    <= fs_d;
            if (wr_hit_d) begin
                mem_q[~sel_q][bus.wr_row_i] <= bus.wr_data_i;
            end
        end
    end

    assign bus.func_o        = row_q;
    assign bus.col_data_o    = col_q;
    assign bus.swap_ack_o    = ack_q;
    assign bus.frame_start_o = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_varredura_matriz.sv
// ============================================================================
// Module  : tb_varredura_matriz
// Brief   : Directed self-checking bench for the row-scan controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_varredura_matriz;
    localparam int DIVM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;

    varredura_matriz_if #(.COLS(5)) bus ();

    varredura_matriz #(.COLS(5), .DIV_WIDTH(16), .DIV_MAX(DIVM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a visible frame and a staged frame, swapped wholesale.
    logic [4:0] shown [1:7];
    logic [4:0] staged[1:7];
    logic [4:0] tmp_fr[1:7];
    bit         m_active, m_pend, m_sw;
    int         m_row, m_cnt;
    logic [2:0] e_func;
    logic [4:0] e_col;
    logic       e_ack, e_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= 7; i++) begin
                shown[i]  = '0;
                staged[i] = '0;
            end
            m_active = 0; m_pend = 0; m_row = 0; m_cnt = 0;
            e_func = 0; e_col = 0; e_ack = 0; e_fs = 0;
        end else begin
            m_sw = m_pend && (!m_active ||
                   (bus.enable_i && m_row == 7 && m_cnt == DIVM));
            if (bus.wr_en_i && bus.wr_row_i != 0) staged[bus.wr_row_i] = bus.wr_data_i;
            if (m_sw) begin
                tmp_fr = shown;
                shown  = staged;
                staged = tmp_fr;
            end
            m_pend = bus.swap_req_i || (m_pend && !m_sw);
            e_ack  = m_sw;
            e_fs   = 0;
            if (!bus.enable_i) begin
                m_active = 0; m_row = 0; m_cnt = 0;
            end else if (!m_active) begin
                m_active = 1; m_row = 1; m_cnt = 0; e_fs = 1;
            end else if (m_cnt == DIVM) begin
                m_cnt = 0;
                if (m_row == 7) begin
                    m_row = 1; e_fs = 1;
                end else begin
                    m_row++;
                end
            end else begin
                m_cnt++;
            end
            e_func = 3'(m_row);
            e_col  = m_active ? shown[m_row] : 5'd0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("model_func",  32'(bus.func_o),        32'(e_func));
            chk("model_col",   32'(bus.col_data_o),    32'(e_col));
            chk("model_ack",   32'(bus.swap_ack_o),    32'(e_ack));
            chk("model_fs",    32'(bus.frame_start_o), 32'(e_fs));
        end
    end

    task automatic wait_func(input logic [2:0] v, input string nm);
        int i;
        i = 0;
        while (bus.func_o !== v && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (bus.func_o !== v) chk(nm, 32'(bus.func_o), 32'(v));
    endtask

    task automatic wait_fs(input string nm);
        int i;
        i = 0;
        while (bus.frame_start_o !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (bus.frame_start_o !== 1'b1) chk(nm, 32'(bus.frame_start_o), 32'd1);
    endtask

    logic [4:0] patt[1:7];
    int nfs, nack;

    initial begin
        patt[1] = 5'b00001; patt[2] = 5'b00010; patt[3] = 5'b00100;
        patt[4] = 5'b01000; patt[5] = 5'b10000; patt[6] = 5'b11111;
        patt[7] = 5'b10101;
        bus.enable_i = 0; bus.wr_en_i = 0; bus.wr_row_i = 0;
        bus.wr_data_i = 0; bus.swap_req_i = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        started = 1;
        repeat (3) @(negedge clk);
        chk("idle_func", 32'(bus.func_o), 32'd0);

        // Scan order with cleared banks
        bus.enable_i = 1;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            chk("scan_func", 32'(bus.func_o), 32'(((k - 1) / 4) % 7 + 1));
            chk("scan_fs",   32'(bus.frame_start_o), 32'(((k - 1) % 28) == 0));
        end

        // Fill shadow, request swap mid-frame
        for (int r = 1; r <= 7; r++) begin
            bus.wr_en_i = 1; bus.wr_row_i = 3'(r); bus.wr_data_i = patt[r];
            @(negedge clk);
            chk("old_frame_col", 32'(bus.col_data_o), 32'd0);
        end
        bus.wr_en_i = 0; bus.swap_req_i = 1;
        @(negedge clk);
        bus.swap_req_i = 0;
        wait_fs("wait_wrap");
        chk("wrap_func", 32'(bus.func_o), 32'd1);
        chk("wrap_col",  32'(bus.col_data_o), 32'b00001);
        chk("wrap_ack",  32'(bus.swap_ack_o), 32'd1);
        @(negedge clk);
        chk("ack_pulse_end", 32'(bus.swap_ack_o), 32'd0);
        wait_func(3'd6, "wait_row6");
        chk("row6_col", 32'(bus.col_data_o), 32'b11111);

        // Abort at row 4 and restart
        wait_func(3'd4, "wait_row4");
        bus.enable_i = 0;
        @(negedge clk);
        chk("abort_func", 32'(bus.func_o), 32'd0);
        chk("abort_col",  32'(bus.col_data_o), 32'd0);
        bus.enable_i = 1;
        @(negedge clk);
        chk("restart_func", 32'(bus.func_o), 32'd1);
        chk("restart_fs",   32'(bus.frame_start_o), 32'd1);
        chk("restart_col",  32'(bus.col_data_o), 32'b00001);
        repeat (3) begin
            @(negedge clk);
            chk("restart_hold", 32'(bus.func_o), 32'd1);
        end
        @(negedge clk);
        chk("restart_row2", 32'(bus.func_o), 32'd2);

        // Idle swap
        bus.enable_i = 0;
        @(negedge clk);
        bus.wr_en_i = 1; bus.wr_row_i = 3; bus.wr_data_i = 5'b11011; bus.swap_req_i = 1;
        @(negedge clk);
        bus.wr_en_i = 0; bus.swap_req_i = 0;
        chk("idle_ack_early", 32'(bus.swap_ack_o), 32'd0);
        @(negedge clk);
        chk("idle_ack", 32'(bus.swap_ack_o), 32'd1);
        @(negedge clk);
        chk("idle_ack_end", 32'(bus.swap_ack_o), 32'd0);
        bus.enable_i = 1;
        @(negedge clk);
        chk("idle_row1_col", 32'(bus.col_data_o), 32'd0);
        wait_func(3'd3, "wait_row3");
        chk("idle_row3_col", 32'(bus.col_data_o), 32'b11011);

        // Write to row 0 is ignored
        bus.wr_en_i = 1; bus.wr_row_i = 0; bus.wr_data_i = 5'b11111;
        @(negedge clk);
        bus.wr_en_i = 0;

        // Write on the swap edge
        bus.enable_i = 0;
        @(negedge clk);
        bus.swap_req_i = 1;
        @(negedge clk);
        bus.swap_req_i = 0;
        bus.wr_en_i = 1; bus.wr_row_i = 2; bus.wr_data_i = 5'b01110;
        @(negedge clk);
        bus.wr_en_i = 0;
        chk("same_edge_ack", 32'(bus.swap_ack_o), 32'd1);
        bus.enable_i = 1;
        wait_func(3'd2, "wait_row2");
        chk("same_edge_col", 32'(bus.col_data_o), 32'b01110);
        wait_func(3'd3, "wait_row3b");
        chk("kept_row3_col", 32'(bus.col_data_o), 32'b00100);

        // Held swap request: one swap per frame boundary
        bus.swap_req_i = 1;
        nfs = 0; nack = 0;
        for (int i = 0; i < 200 && nfs < 3; i++) begin
            @(negedge clk);
            if (bus.frame_start_o === 1'b1) nfs++;
            if (bus.swap_ack_o === 1'b1) nack++;
        end
        bus.swap_req_i = 0;
        chk("held_frames", 32'(nfs), 32'd3);
        chk("held_acks", 32'(nack), 32'd3);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-scan
        #2 rst = 1;
        #1;
        chk("rst_func", 32'(bus.func_o), 32'd0);
        chk("rst_col",  32'(bus.col_data_o), 32'd0);
        chk("rst_ack",  32'(bus.swap_ack_o), 32'd0);
        chk("rst_fs",   32'(bus.frame_start_o), 32'd0);
        @(negedge clk);
        bus.enable_i = 0;
        @(negedge clk);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_func", 32'(bus.func_o), 32'd0);
        end
        bus.enable_i = 1;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
